// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB slave types, response codes and lane-mask helper
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_t;

   // Byte enables for an aligned, in-range access; size is HSIZE[1:0].
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    lane_mask = 4'b0001 << off;
         2'd1:    lane_mask = 4'b0011 << {off[1], 1'b0};
         default: lane_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// rtl/ahb_sram_mem.sv - word array with byte-lane write enables and async read port
module ahb_sram_mem #(
   parameter int MEM_DEPTH  = 256,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_BITS   = $clog2(MEM_DEPTH)
) (
   input  logic                  HCLK,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [IDX_BITS-1:0]   addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge HCLK) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave: address-phase decode, wait/error FSM
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HRESP
);

   localparam int IDX_BITS = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);

   slave_state_t          state, state_nxt, accept_tgt;
   logic [3:0]            wait_cnt;
   logic [IDX_BITS+1:0]   addr_q;
   logic [1:0]            size_q;
   logic                  write_q;
   logic                  accept, addr_err, mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // HREADYOUT gating keeps a stalled data phase from re-capturing control.
   assign accept = HSEL && HREADY && HREADYOUT &&
                   (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);

   assign addr_err = (HADDR >= ADDR_LIMIT) || (HSIZE > HSIZE_WORD) ||
                     (HSIZE == HSIZE_HALF && HADDR[0]) ||
                     (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);

   assign accept_tgt = addr_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_DATA);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         addr_q   <= '0;
         size_q   <= 2'd0;
         write_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_WAIT && state_nxt == ST_WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
         end else begin
            wait_cnt <= 4'd0;
         end
         if (accept) begin
            addr_q  <= HADDR[IDX_BITS+1:0];
            size_q  <= HSIZE[1:0];
            write_q <= HWRITE;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DATA, ST_ERR2: state_nxt = accept ? accept_tgt : ST_IDLE;
         ST_WAIT: if (wait_cnt == 4'(WAIT_STATES - 1)) state_nxt = ST_DATA;
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      HREADYOUT = !(state == ST_WAIT || state == ST_ERR1);
      HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
      mem_we    = (state == ST_DATA) && write_q;
      HRDATA    = ((state == ST_DATA) && !write_q) ? mem_rdata : '0;
   end

   ahb_sram_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .DATA_WIDTH(DATA_WIDTH),
      .IDX_BITS  (IDX_BITS)
   ) u_mem (
      .HCLK (HCLK),
      .we   (mem_we),
      .be   (lane_mask(size_q, addr_q[1:0])),
      .addr (addr_q[IDX_BITS+1:2]),
      .wdata(HWDATA),
      .rdata(mem_rdata)
   );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave (WAIT_STATES=1 and 0)
module tb_ahb_sram_slave;

   logic        clk;
   logic        rst       [2];
   logic        hsel      [2];
   logic [31:0] haddr     [2];
   logic [1:0]  htrans    [2];
   logic        hwrite    [2];
   logic [2:0]  hsize     [2];
   logic [31:0] hwdata    [2];
   logic        hreadyout [2];
   logic [31:0] hrdata    [2];
   logic        hresp     [2];

   int          total = 0;
   int          bad   = 0;
   int          ws [2] = '{1, 0};
   logic [31:0] mm [2][256];

   ahb_sram_slave #(.WAIT_STATES(1)) u_dut_ws1 (
      .HCLK(clk), .HRESET(rst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
      .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]),
      .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0])
   );

   ahb_sram_slave #(.WAIT_STATES(0)) u_dut_ws0 (
      .HCLK(clk), .HRESET(rst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
      .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]),
      .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size);
      if (addr >= 32'd1024) return 1'b1;
      if (size > 3'd2) return 1'b1;
      if (size == 3'd1 && addr % 2 != 0) return 1'b1;
      if (size == 3'd2 && addr % 4 != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_idle(input int d, input string tag);
      chk({tag, "_hreadyout"}, 32'(hreadyout[d]), 32'd1);
      chk({tag, "_hresp"},     32'(hresp[d]),     32'd0);
      chk({tag, "_hrdata"},    hrdata[d],         32'd0);
   endtask

   // Called at a negedge; returns at the negedge of the final data-phase cycle
   // so the caller may issue the next address phase in that same cycle.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
      bit err;
      int lows;
      int lane;
      err  = model_err(addr, size);
      lows = err ? 1 : ws[d];
      hsel[d]   = 1'b1;
      htrans[d] = ($urandom % 2) ? 2'd2 : 2'd3;
      haddr[d]  = addr;
      hwrite[d] = wr;
      hsize[d]  = size;
      @(negedge clk);
      hwdata[d] = wdata;
      hsel[d]   = 1'($urandom % 2);
      htrans[d] = 2'($urandom % 2);
      haddr[d]  = $urandom;
      hwrite[d] = 1'($urandom % 2);
      hsize[d]  = 3'($urandom % 8);
      for (int c = 0; c < lows; c++) begin
         chk("dp_wait_hreadyout", 32'(hreadyout[d]), 32'd0);
         chk("dp_wait_hresp",     32'(hresp[d]),     32'(err));
         chk("dp_wait_hrdata",    hrdata[d],         32'd0);
         @(negedge clk);
      end
      chk("dp_last_hreadyout", 32'(hreadyout[d]), 32'd1);
      chk("dp_last_hresp",     32'(hresp[d]),     32'(err));
      chk("dp_last_hrdata",    hrdata[d], (!wr && !err) ? mm[d][addr[9:2]] : 32'd0);
      if (wr && !err) begin
         for (int i = 0; i < (1 << size); i++) begin
            lane = int'(addr % 4) + i;
            mm[d][addr[9:2]][lane*8 +: 8] = wdata[lane*8 +: 8];
         end
      end
   endtask

   task automatic go_idle(input int d, input int n);
      hsel[d]   = 1'b0;
      htrans[d] = 2'd0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_idle(d, "idle");
      end
   endtask

   task automatic random_run(input int d, input int n);
      logic [31:0] a;
      logic [2:0]  s;
      int r;
      for (int k = 0; k < n; k++) begin
         r = int'($urandom % 8);
         if (r == 0)      a = 32'h400 + ($urandom % 256);
         else if (r == 1) a = $urandom | 32'h400;
         else             a = $urandom % 64;
         s = ($urandom % 8 < 6) ? 3'($urandom % 3) : 3'($urandom % 8);
         xfer(d, 1'($urandom % 2), a, s, $urandom);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'd0;
         hwrite[d] = 1'b0; hsize[d] = 3'd0; hwdata[d] = '0;
      end
      @(negedge clk);
      @(negedge clk);
      check_idle(0, "reset_ws1");
      check_idle(1, "reset_ws0");
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);

      for (int w = 0; w < 16; w++) xfer(0, 1'b1, 32'(w * 4), 3'd2, $urandom);
      xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
      go_idle(0, 1);
      xfer(0, 1'b1, 32'h10, 3'd2, 32'h11223344);
      xfer(0, 1'b1, 32'h13, 3'd0, 32'hAA000000);
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);
      xfer(0, 1'b0, 32'h402, 3'd2, 32'h0);
      xfer(0, 1'b1, 32'h402, 3'd2, 32'hCAFEF00D);
      xfer(0, 1'b0, 32'h0, 3'd2, 32'h0);
      go_idle(0, 1);

      hsel[0]   = 1'b1;
      htrans[0] = 2'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle(0, "busy");
      end
      xfer(0, 1'b0, 32'h10, 3'd2, 32'h0);

      hsel[0] = 1'b1; htrans[0] = 2'd2; haddr[0] = 32'h20; hwrite[0] = 1'b1; hsize[0] = 3'd2;
      @(negedge clk);
      hsel[0] = 1'b0; htrans[0] = 2'd0; hwdata[0] = 32'h1234;
      chk("rst_pre_hreadyout", 32'(hreadyout[0]), 32'd0);
      #1 rst[0] = 1'b1;
      #1 check_idle(0, "rst_mid");
      #1 rst[0] = 1'b0;
      @(negedge clk);
      check_idle(0, "rst_after");
      xfer(0, 1'b0, 32'h20, 3'd2, 32'h0);
      random_run(0, 40);
      go_idle(0, 1);

      for (int w = 0; w < 16; w++) xfer(1, 1'b1, 32'(w * 4), 3'd2, $urandom);
      xfer(1, 1'b1, 32'h0, 3'd2, 32'h5);
      xfer(1, 1'b0, 32'h0, 3'd2, 32'h0);
      xfer(1, 1'b1, 32'h6, 3'd1, 32'hBEEF0000);
      xfer(1, 1'b0, 32'h4, 3'd2, 32'h0);
      random_run(1, 40);
      go_idle(1, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
